regfile_write_arbiter: RTL and testbench

//  Shares the single register-file write port (RegWrite/WriteAddr/WriteData) among
//  NUM_REQ writeback sources (ALU, load unit, mult/div). Round-robin arbitration,

---
 rtl/regfile_write_arbiter.sv | 77 +++++++
 tb/tb_regfile_write_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port
// among several writeback sources, with one registered output stage.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      wr_stall,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         WriteAddr,
  output logic [DATA_W-1:0]         WriteData,
  output logic                      busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  win;
  logic [PTR_W-1:0]  idx;
  logic              found;
  logic [NUM_REQ-1:0] grant;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              accept;

  // Scan requesters starting at rr_ptr; first valid one wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // One-hot grant, blocked by stall and reset; pick winner payload.
  always_comb begin
    grant = '0;
    if (found && !wr_stall && !rst)
      grant[win] = 1'b1;
    win_addr = req_addr[int'(win)*ADDR_W +: ADDR_W];
    win_data = req_data[int'(win)*DATA_W +: DATA_W];
  end

  assign req_ready = grant;
  assign accept    = |grant;
  assign busy      = (|req_valid) | RegWrite;

  // Output stage and pointer; writes to x0 complete but never enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite  <= 1'b0;
      WriteAddr <= '0;
      WriteData <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      WriteAddr <= win_addr;
      WriteData <= win_data;
      RegWrite  <= (win_addr != '0);
      rr_ptr    <= (win == PTR_W'(NUM_REQ-1)) ? '0
                                              : win + PTR_W'(1);
    end else begin
      RegWrite  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with immediate-assertion
// checks at each step.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        wr_stall;
  logic        RegWrite;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic        busy;

  int vectors;
  int miscompares;

  regfile_write_arbiter #(
    .NUM_REQ(3),
    .ADDR_W(5),
    .DATA_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_data(req_data),
    .req_ready(req_ready),
    .wr_stall(wr_stall),
    .RegWrite(RegWrite),
    .WriteAddr(WriteAddr),
    .WriteData(WriteData),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i,
                         input logic [4:0] a,
                         input logic [31:0] d);
    req_addr[i*5 +: 5]   = a;
    req_data[i*32 +: 32] = d;
  endtask

  initial begin
    logic [2:0]  exp_rdy [6];
    logic [4:0]  exp_adr [6];
    logic [31:0] exp_dat [6];
    vectors     = 0;
    miscompares = 0;

    // 1: reset with all requesters valid
    rst       = 1'b1;
    wr_stall  = 1'b0;
    req_valid = 3'b111;
    req_addr  = '0;
    req_data  = '0;
    set_req(0, 5'd1, 32'h0000_0001);
    set_req(1, 5'd2, 32'h0000_0002);
    set_req(2, 5'd3, 32'h0000_0003);
    #2;
    check("rst_ready_t0", 32'(req_ready), 32'h0);
    check("rst_regwr_t0", 32'(RegWrite), 32'h0);
    tick();
    tick();
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_regwr", 32'(RegWrite), 32'h0);
    check("rst_addr", 32'(WriteAddr), 32'h0);
    check("rst_data", WriteData, 32'h0);
    check("rst_busy", 32'(busy), 32'h1);
    rst = 1'b0;
    #1;
    check("post_rst_grant0", 32'(req_ready), 32'h1);
    req_valid = 3'b000;
    #1;
    check("idle_ready", 32'(req_ready), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);
    tick();
    check("idle_regwr", 32'(RegWrite), 32'h0);

    // 2: single request from req1
    set_req(1, 5'd5, 32'hDEAD_BEEF);
    req_valid = 3'b010;
    #1;
    check("single_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 3'b000;
    check("single_regwr", 32'(RegWrite), 32'h1);
    check("single_addr", 32'(WriteAddr), 32'h5);
    check("single_data", WriteData, 32'hDEAD_BEEF);
    tick();
    check("single_drop", 32'(RegWrite), 32'h0);
    check("single_hold", 32'(WriteAddr), 32'h5);

    // 4: zero register via req2 (rr_ptr is 2 here)
    set_req(2, 5'd0, 32'h0000_1234);
    req_valid = 3'b100;
    #1;
    check("zero_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 3'b000;
    check("zero_regwr", 32'(RegWrite), 32'h0);
    check("zero_data", WriteData, 32'h0000_1234);

    // 3: round robin, all valid for six cycles
    set_req(0, 5'd10, 32'hA0A0_0010);
    set_req(1, 5'd11, 32'hB1B1_0011);
    set_req(2, 5'd12, 32'hC2C2_0012);
    exp_rdy = '{3'b001, 3'b010, 3'b100,
                3'b001, 3'b010, 3'b100};
    exp_adr = '{5'd10, 5'd11, 5'd12,
                5'd10, 5'd11, 5'd12};
    exp_dat = '{32'hA0A0_0010, 32'hB1B1_0011,
                32'hC2C2_0012, 32'hA0A0_0010,
                32'hB1B1_0011, 32'hC2C2_0012};
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr_ready%0d", k),
            32'(req_ready), 32'(exp_rdy[k]));
      tick();
      if (k == 5) req_valid = 3'b000;
      check($sformatf("rr_regwr%0d", k),
            32'(RegWrite), 32'h1);
      check($sformatf("rr_addr%0d", k),
            32'(WriteAddr), 32'(exp_adr[k]));
      check($sformatf("rr_data%0d", k),
            WriteData, exp_dat[k]);
    end
    tick();
    check("rr_end_regwr", 32'(RegWrite), 32'h0);

    // 5: stall holds off req0 for three cycles
    set_req(0, 5'd3, 32'hCAFE_0003);
    req_valid = 3'b001;
    wr_stall  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall_ready%0d", k),
            32'(req_ready), 32'h0);
      check($sformatf("stall_busy%0d", k),
            32'(busy), 32'h1);
      tick();
      check($sformatf("stall_regwr%0d", k),
            32'(RegWrite), 32'h0);
      check($sformatf("stall_addr%0d", k),
            32'(WriteAddr), 32'd12);
    end
    wr_stall = 1'b0;
    #1;
    check("unstall_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 3'b000;
    check("unstall_regwr", 32'(RegWrite), 32'h1);
    check("unstall_addr", 32'(WriteAddr), 32'h3);
    check("unstall_data", WriteData, 32'hCAFE_0003);
    tick();
    check("unstall_drop", 32'(RegWrite), 32'h0);

    // rr_ptr is 1: req1 idle, so req2 must beat req0
    set_req(0, 5'd10, 32'hA0A0_0010);
    req_valid = 3'b101;
    #1;
    check("skip_ready", 32'(req_ready), 32'h4);
    tick();
    check("skip_addr", 32'(WriteAddr), 32'd12);
    check("wrap_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 3'b000;
    check("wrap_addr", 32'(WriteAddr), 32'd10);
    check("wrap_regwr", 32'(RegWrite), 32'h1);
    tick();

    // 6: reset drops an in-flight write (rr_ptr is 1)
    set_req(1, 5'd7, 32'h0000_0077);
    req_valid = 3'b010;
    #1;
    check("mid_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 3'b000;
    check("mid_regwr_pre", 32'(RegWrite), 32'h1);
    rst = 1'b1;
    #1;
    check("mid_regwr_rst", 32'(RegWrite), 32'h0);
    check("mid_addr_rst", 32'(WriteAddr), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check("mid_regwr_after", 32'(RegWrite), 32'h0);
    check("mid_busy_after", 32'(busy), 32'h0);
    req_valid = 3'b110;
    #1;
    check("mid_ptr_reset", 32'(req_ready), 32'h2);
    req_valid = 3'b000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
